dmem_uart_tx_mmio: RTL and testbench
====================================

Name: dmem_uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the processor's dmem port, downstream of the processor.
- Intercepts stores to a reserved dmem word, queues the low byte in a FIFO, and serialises 8N1 on uart_tx.
- Gates RAM write-enable for the MMIO window and muxes a status word into the processor's read data.
- Clocked on the same edge as dmem, so read latency matches the RAM.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2
FIFO_DEPTH, 16, byte FIFO entries; power of two, 2..256
TX_ADDR, 12'hFFF, dmem word address of the TX data register
STATUS_ADDR, 12'hFFE, dmem word address of the status/control register

Ports:
clock  in  1  single system clock (same clock as dmem_clock); all logic on rising edge
reset  in  1  synchronous, active-high reset
address_dmem  in  12  dmem address from processor
data  in  32  dmem write data from processor
wren  in  1  dmem write enable from processor
q_ram  in  32  read data from the dmem RAM
dmem_wren  out  1  write enable to the dmem RAM, gated
q_dmem  out  32  read data to the processor
uart_tx  out  1  serial output, idle high
tx_busy  out  1  high while a frame is on the wire
fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, one edge: FIFO emptied, FSM to IDLE, uart_tx=1, tx_busy=0, overflow=0, fifo_count=0, read-select register=0, so q_dmem=q_ram.
- Address decode: mmio_hit = address_dmem equals TX_ADDR or STATUS_ADDR. dmem_wren = wren & ~mmio_hit (combinational).
- Push: wren and address TX_ADDR and FIFO not full -> data[7:0] written at that edge; data[31:8] ignored.
- Push while full: byte dropped, overflow set (sticky).
- Push and pop on the same edge: both happen, so count is unchanged. This includes the full case: a pop frees a slot and the push is accepted.
- Status write: wren and address STATUS_ADDR with data[0]=1 clears overflow. All other bits are ignored. A write with data[0]=0 has no effect.
- If an overflow set and a clear land on the same edge, set wins.
- Status word: bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow, bits[4+:log2(DEPTH)+1] fifo_count, rest 0.
- Read path: at each edge, register sel = (address_dmem==STATUS_ADDR) and snapshot the status word.
  - q_dmem = sel ? snapshot : q_ram. Latency is 1 cycle, identical to the RAM.
  - A read of TX_ADDR returns q_ram; no side effect.
- TX FSM states IDLE, START, DATA, STOP. The baud counter runs 0..CLKS_PER_BIT-1; bit_idx runs 0..7.
  - IDLE: uart_tx=1, tx_busy=0. If FIFO not empty: pop into shift register, counter=0, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right and bit_idx++. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - IDLE always lasts at least 1 cycle, so the gap between back-to-back frames is exactly 1 clock.
  - tx_busy=1 in START, DATA and STOP. uart_tx and tx_busy are registered outputs.
- Latency: push at edge N. fifo_count=1 after N. Pop at N+1, and uart_tx falls after N+1. A frame lasts 10*CLKS_PER_BIT cycles.
- FIFO pointers wrap modulo FIFO_DEPTH. Full is count==FIFO_DEPTH; empty is count==0.
- Reset mid-frame: the frame is aborted and uart_tx=1 after the reset edge. Pending bytes are lost.

Decomposition:
- Package mmio_pkg: TX_ADDR/STATUS_ADDR defaults, status bit indices (ST_FULL=0, ST_EMPTY=1, ST_BUSY=2, ST_OVF=3, ST_COUNT_LSB=4), tx_state enum (IDLE, START, DATA, STOP).
- Sub-module mmio_byte_fifo:
  - Parameter DEPTH.
  - Ports: clock, reset, push, din[7:0], pop, dout[7:0], full, empty, count.
  - Show-ahead: dout is valid whenever not empty.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset then store 0x000000A5 to 0xFFF -> dmem_wren stays 0. uart_tx is low from N+2 to N+5, then carries 1,0,1,0,0,1,0,1 at 4 cycles each, then high. tx_busy is high for 40 cycles.
- Store 0x12345678 to address 0x010 -> dmem_wren=1 and FIFO untouched. Read 0x010 -> q_dmem=q_ram one cycle later.
- 6 stores to 0xFFF on consecutive cycles while idle:
  - first pop after write 1; writes 2-5 fill the FIFO to 4; write 6 is dropped.
  - status read -> overflow=1, full=1, busy=1.
  - 5 frames then appear, in write order, with 1-cycle gaps.
- Write 0x1 to 0xFFE -> status reads back with overflow=0. Write 0x0 -> overflow unchanged.
- Store to 0xFFF on the same edge the FSM pops, with FIFO full -> count stays 4 and no overflow.
- Assert reset during DATA bit 3 -> uart_tx=1, tx_busy=0 and fifo_count=0 after that edge, and status reads 0x00000002.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and types for the dmem-mapped UART transmitter.
// Default register addresses, status word layout and TX FSM state encoding.
package mmio_pkg;

   localparam logic [11:0] TX_ADDR_DEF     = 12'hFFF;
   localparam logic [11:0] STATUS_ADDR_DEF = 12'hFFE;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/mmio_byte_fifo.sv
// Show-ahead byte FIFO: dout presents the oldest entry whenever not empty.
// A pop frees a slot in the same edge, so push+pop while full is accepted.
module mmio_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == FULL_CNT);
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   // Storage carries no reset; occupancy is governed solely by r_count.
   always_ff @(posedge clock) begin
      if (w_do_push && !reset)
         r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_uart_tx_mmio.sv
// dmem-side UART transmitter: stores to TX_ADDR queue a byte for 8N1 output,
// STATUS_ADDR reads return a status snapshot with the same 1-cycle latency as RAM.
module dmem_uart_tx_mmio
   import mmio_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [11:0] TX_ADDR      = TX_ADDR_DEF,
   parameter logic [11:0] STATUS_ADDR  = STATUS_ADDR_DEF
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [11:0]                   address_dmem,
   input  logic [31:0]                   data,
   input  logic                          wren,
   input  logic [31:0]                   q_ram,
   output logic                          dmem_wren,
   output logic [31:0]                   q_dmem,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("CLKS_PER_BIT must be at least 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 2..256");
   end

   logic          w_tx_hit;
   logic          w_st_hit;
   logic          w_push_req;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_dout;
   logic [AW:0]   w_count;
   logic          w_ovf_set;
   logic          w_ovf_clr;
   logic [31:0]   w_status;
   logic          w_unused_data;

   tx_state_e     r_state;
   logic [CW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_busy;
   logic          r_ovf;
   logic          r_sel;
   logic [31:0]   r_status;

   // Address decode and RAM write gating
   assign w_tx_hit      = (address_dmem == TX_ADDR);
   assign w_st_hit      = (address_dmem == STATUS_ADDR);
   assign dmem_wren     = wren & ~(w_tx_hit | w_st_hit);
   assign w_push_req    = wren & w_tx_hit;
   assign w_pop         = (r_state == IDLE) & ~w_empty;
   assign w_ovf_set     = w_push_req & w_full & ~w_pop;
   assign w_ovf_clr     = wren & w_st_hit & data[0];
   assign w_unused_data = ^data[31:8];

   mmio_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push_req),
      .din   (data[7:0]),
      .pop   (w_pop),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   always_comb begin
      w_status                       = '0;
      w_status[ST_FULL]              = w_full;
      w_status[ST_EMPTY]             = w_empty;
      w_status[ST_BUSY]              = r_busy;
      w_status[ST_OVF]               = r_ovf;
      w_status[ST_COUNT_LSB +: AW+1] = w_count;
   end

   // Overflow is sticky; a set on the same edge as a clear wins.
   always_ff @(posedge clock) begin
      if (reset)
         r_ovf <= 1'b0;
      else if (w_ovf_set)
         r_ovf <= 1'b1;
      else if (w_ovf_clr)
         r_ovf <= 1'b0;
   end

   // Read path registered on the dmem edge so latency matches the RAM
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sel    <= 1'b0;
         r_status <= '0;
      end else begin
         r_sel    <= w_st_hit;
         r_status <= w_status;
      end
   end

   assign q_dmem = r_sel ? r_status : q_ram;

   // 8N1 serialiser; uart_tx is presented one cycle ahead from r_shift
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_shift <= w_dout;
                  r_baud  <= '0;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= START;
               end
            end
            START: begin
               if (r_baud == BAUD_MAX) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            DATA: begin
               if (r_baud == BAUD_MAX) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            STOP: begin
               if (r_baud == BAUD_MAX) begin
                  r_baud  <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign uart_tx    = r_tx;
   assign tx_busy    = r_busy;
   assign fifo_count = w_count;

endmodule

// File: tb/tb_dmem_uart_tx_mmio.sv
// Directed bench for dmem_uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dmem_uart_tx_mmio;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] address_dmem = 12'h000;
   logic [31:0] data = 32'h0;
   logic        wren = 1'b0;
   logic [31:0] q_ram = 32'hCAFEF00D;
   logic        dmem_wren;
   logic [31:0] q_dmem;
   logic        uart_tx;
   logic        tx_busy;
   logic [2:0]  fifo_count;

   int n_pass  = 0;
   int n_total = 0;

   dmem_uart_tx_mmio #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .TX_ADDR      (12'hFFF),
      .STATUS_ADDR  (12'hFFE)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_ram        (q_ram),
      .dmem_wren    (dmem_wren),
      .q_dmem       (q_dmem),
      .uart_tx      (uart_tx),
      .tx_busy      (tx_busy),
      .fifo_count   (fifo_count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks frame samples first..39 (sample 0 = first start-bit cycle), then the idle gap.
   task automatic frame_chk(input logic [7:0] b, input int first);
      logic e;
      for (int k = first; k < 10*CPB; k++) begin
         cyc();
         if (k < CPB)          e = 1'b0;
         else if (k >= 9*CPB)  e = 1'b1;
         else                  e = b[k/CPB - 1];
         chk($sformatf("tx_%02h_s%0d", b, k), 32'(uart_tx), 32'(e));
         chk($sformatf("busy_%02h_s%0d", b, k), 32'(tx_busy), 32'd1);
      end
      cyc();
      chk($sformatf("gap_tx_%02h", b), 32'(uart_tx), 32'd1);
      chk($sformatf("gap_busy_%02h", b), 32'(tx_busy), 32'd0);
   endtask

   task automatic store(input logic [11:0] a, input logic [31:0] d);
      address_dmem = a;
      data         = d;
      wren         = 1'b1;
      cyc();
      wren         = 1'b0;
      address_dmem = 12'h000;
      data         = 32'h0;
   endtask

   initial begin
      int waited;

      // Reset state
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_tx", 32'(uart_tx), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_qdmem", q_dmem, 32'hCAFEF00D);

      // Single byte 0xA5
      address_dmem = 12'hFFF;
      data         = 32'h000000A5;
      wren         = 1'b1;
      #1;
      chk("tx_store_wren", 32'(dmem_wren), 32'd0);
      cyc();
      wren = 1'b0;
      address_dmem = 12'h000;
      chk("a5_count_after_push", 32'(fifo_count), 32'd1);
      chk("a5_tx_before_pop", 32'(uart_tx), 32'd1);
      frame_chk(8'hA5, 0);
      chk("a5_count_end", 32'(fifo_count), 32'd0);

      // Ordinary RAM store and reads pass through
      address_dmem = 12'h010;
      data         = 32'h12345678;
      wren         = 1'b1;
      #1;
      chk("ram_store_wren", 32'(dmem_wren), 32'd1);
      cyc();
      wren = 1'b0;
      chk("ram_store_count", 32'(fifo_count), 32'd0);
      chk("ram_store_busy", 32'(tx_busy), 32'd0);
      q_ram = 32'h11112222;
      cyc();
      chk("ram_read_q", q_dmem, 32'h11112222);
      address_dmem = 12'hFFF;
      q_ram = 32'h33334444;
      cyc();
      chk("txaddr_read_q", q_dmem, 32'h33334444);
      chk("txaddr_read_count", 32'(fifo_count), 32'd0);
      address_dmem = 12'h000;

      // Six back-to-back pushes into a depth-4 FIFO
      store(12'hFFF, 32'hABCDEF11);
      chk("burst_w1_count", 32'(fifo_count), 32'd1);
      store(12'hFFF, 32'hABCDEF22);
      chk("burst_w2_count", 32'(fifo_count), 32'd1);
      chk("burst_w2_start", 32'(uart_tx), 32'd0);
      store(12'hFFF, 32'hABCDEF33);
      store(12'hFFF, 32'hABCDEF44);
      store(12'hFFF, 32'hABCDEF55);
      chk("burst_w5_count", 32'(fifo_count), 32'd4);
      store(12'hFFF, 32'hABCDEF66);
      chk("burst_w6_count", 32'(fifo_count), 32'd4);
      address_dmem = 12'hFFE;
      cyc();
      address_dmem = 12'h000;
      chk("burst_status", q_dmem, 32'h0000004D);
      frame_chk(8'h11, 6);
      frame_chk(8'h22, 0);
      frame_chk(8'h33, 0);
      frame_chk(8'h44, 0);
      frame_chk(8'h55, 0);
      chk("burst_count_end", 32'(fifo_count), 32'd0);
      repeat (8) cyc();
      chk("burst_dropped_tx", 32'(uart_tx), 32'd1);
      chk("burst_dropped_busy", 32'(tx_busy), 32'd0);

      // Status writes: bit0=0 leaves overflow, bit0=1 clears it
      address_dmem = 12'hFFE;
      data         = 32'h00000000;
      wren         = 1'b1;
      #1;
      chk("status_store_wren", 32'(dmem_wren), 32'd0);
      cyc();
      wren = 1'b0;
      cyc();
      chk("status_after_wr0", q_dmem, 32'h0000000A);
      data = 32'h00000001;
      wren = 1'b1;
      cyc();
      wren = 1'b0;
      cyc();
      chk("status_after_wr1", q_dmem, 32'h00000002);
      address_dmem = 12'h000;
      data = 32'h0;

      // Fill, then push on the very edge the FSM pops while full
      store(12'hFFF, 32'h0000003C);
      store(12'hFFF, 32'h000000C3);
      store(12'hFFF, 32'h0000005A);
      store(12'hFFF, 32'h00000096);
      store(12'hFFF, 32'h0000000F);
      chk("fill_count", 32'(fifo_count), 32'd4);
      waited = 0;
      while (tx_busy === 1'b1 && waited < 100) begin
         cyc();
         waited++;
      end
      chk("fill_frame_done", 32'(waited < 100), 32'd1);
      chk("fill_count_idle", 32'(fifo_count), 32'd4);
      store(12'hFFF, 32'h000000F0);
      chk("pushpop_count", 32'(fifo_count), 32'd4);
      chk("pushpop_start", 32'(uart_tx), 32'd0);
      address_dmem = 12'hFFE;
      cyc();
      address_dmem = 12'h000;
      chk("pushpop_status", q_dmem, 32'h00000045);

      // Reset in the middle of data bit 3 of 0xC3 (bit value 0)
      repeat (16) cyc();
      chk("bit3_tx", 32'(uart_tx), 32'd0);
      chk("bit3_busy", 32'(tx_busy), 32'd1);
      reset = 1'b1;
      address_dmem = 12'hFFE;
      q_ram = 32'h55556666;
      cyc();
      reset = 1'b0;
      chk("midrst_tx", 32'(uart_tx), 32'd1);
      chk("midrst_busy", 32'(tx_busy), 32'd0);
      chk("midrst_count", 32'(fifo_count), 32'd0);
      chk("midrst_q_ram", q_dmem, 32'h55556666);
      cyc();
      chk("midrst_status", q_dmem, 32'h00000002);
      address_dmem = 12'h000;
      repeat (5) cyc();
      chk("midrst_quiet_tx", 32'(uart_tx), 32'd1);
      chk("midrst_quiet_count", 32'(fifo_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
